// File: rtl/s_stream_feeder_pkg.sv
// s_stream_feeder_pkg
//   Constants and types shared by the s-stream feeder and its users.
//   PE_Array_size_log sets the PE array size and therefore the chunk size:
//   one chunk (one memory word) carries 2^PE_Array_size_log two-bit characters.
package s_stream_feeder_pkg;

  localparam int PE_Array_size_log = 6;

  // Characters packed into one 128-bit memory word / one chunk.
  localparam int CHARS_PER_WORD = 1 << PE_Array_size_log;

  // Tag for "full chunk, more follow": all ones in the core's valid-count field.
  localparam logic [PE_Array_size_log:0] FULL_CHUNK_TAG = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // re-arm: pointer cleared, total re-sampled
    ST_FILL = 2'd1,  // memory read strobe for the current word
    ST_HOLD = 2'd2,  // word available (first cycle straight from memory)
    ST_SEND = 2'd3   // one-cycle chunk pulse toward the core
  } feeder_state_e;

endpackage

// File: rtl/s_stream_feeder.sv
// s_stream_feeder
//   Streams query sequence s from an on-chip word memory into the
//   Smith-Waterman core, one chunk per o_request_s from the core, tagged with
//   the core's valid-count encoding. After the last chunk it wraps to word 0
//   so each pass of the PE array can re-stream s.
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous active-high reset (priority over i_busy)
//   i_busy       core busy; low forces IDLE and re-arms the feeder
//   i_request_s  core asks for the next chunk (level, held until served)
//   i_s_total    total characters of s, sampled while idle
//   o_mem_en     memory read strobe
//   o_mem_addr   memory word address
//   i_mem_rdata  memory data, valid exactly one cycle after o_mem_en
//   o_s          chunk data, zero when o_s_valid is 0
//   o_s_valid    chunk tag: 0 none, all-ones full chunk, 1..64 last chunk
module s_stream_feeder
  import s_stream_feeder_pkg::*;
#(
  parameter int PE_LOG = PE_Array_size_log,
  parameter int ADDR_W = 8,
  parameter int S_W    = 2 * (1 << PE_LOG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_busy,
  input  logic              i_request_s,
  input  logic [14:0]       i_s_total,
  output logic              o_mem_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [S_W-1:0]    i_mem_rdata,
  output logic [S_W-1:0]    o_s,
  output logic [PE_LOG:0]   o_s_valid
);

  localparam int TOT_W = 15;
  localparam logic [TOT_W-1:0] CHUNK_T   = TOT_W'(CHARS_PER_WORD);
  // Largest s the memory can hold: every word full.
  localparam logic [TOT_W-1:0] MAX_TOTAL = TOT_W'(CHARS_PER_WORD << ADDR_W);

  feeder_state_e     state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [TOT_W-1:0]  remain_q, remain_d;
  logic [TOT_W-1:0]  total_q, total_d;
  logic [S_W-1:0]    buf_q, buf_d;
  logic              buf_vld_q, buf_vld_d;
  logic              mem_en_q, mem_en_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [S_W-1:0]    s_q, s_d;
  logic [PE_LOG:0]   s_valid_q, s_valid_d;

  logic [TOT_W-1:0]  sat_total;
  logic [S_W-1:0]    hold_data;
  logic              last_chunk;

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    remain_d   = remain_q;
    total_d    = total_q;
    buf_d      = buf_q;
    buf_vld_d  = buf_vld_q;
    mem_en_d   = 1'b0;
    mem_addr_d = '0;
    s_d        = '0;
    s_valid_d  = '0;

    sat_total  = (i_s_total > MAX_TOTAL) ? MAX_TOTAL : i_s_total;
    // Read data is only on the bus for the first HOLD cycle; after that the
    // captured copy is the source.
    hold_data  = buf_vld_q ? buf_q : i_mem_rdata;
    last_chunk = (remain_q <= CHUNK_T);

    if (!i_busy) begin
      // Abort from any state; an outstanding read is simply not captured.
      state_d   = ST_IDLE;
      ptr_d     = '0;
      remain_d  = sat_total;
      total_d   = sat_total;
      buf_vld_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          ptr_d     = '0;
          remain_d  = sat_total;
          total_d   = sat_total;
          buf_vld_d = 1'b0;
          if (sat_total != '0) state_d = ST_FILL;
        end
        ST_FILL: begin
          buf_vld_d = 1'b0;
          state_d   = ST_HOLD;
        end
        ST_HOLD: begin
          buf_d     = hold_data;
          buf_vld_d = 1'b1;
          if (i_request_s) begin
            state_d   = ST_SEND;
            s_d       = hold_data;
            s_valid_d = last_chunk ? remain_q[PE_LOG:0] : FULL_CHUNK_TAG;
            if (last_chunk) begin
              // Wrap so the next pass re-streams s from the start.
              ptr_d    = '0;
              remain_d = total_q;
            end else begin
              ptr_d    = ptr_q + 1'b1;
              remain_d = remain_q - CHUNK_T;
            end
          end
        end
        ST_SEND: begin
          buf_vld_d = 1'b0;
          state_d   = ST_FILL;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Outputs are registered: the strobe is high exactly while in FILL.
    if (state_d == ST_FILL) begin
      mem_en_d   = 1'b1;
      mem_addr_d = ptr_d;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples values from before the edge regardless of process order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      remain_q   <= '0;
      total_q    <= '0;
      buf_vld_q  <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
      s_q        <= '0;
      s_valid_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      remain_q   <= remain_d;
      total_q    <= total_d;
      buf_vld_q  <= buf_vld_d;
      mem_en_q   <= mem_en_d;
      mem_addr_q <= mem_addr_d;
      s_q        <= s_d;
      s_valid_q  <= s_valid_d;
    end
  end

  // NOTE: the prefetch buffer is a data register guarded by buf_vld_q, so it
  // carries no reset; its contents are never used until rewritten.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign o_mem_en   = mem_en_q;
  assign o_mem_addr = mem_addr_q;
  assign o_s        = s_q;
  assign o_s_valid  = s_valid_q;

endmodule

// File: tb/tb_s_stream_feeder.sv
// tb_s_stream_feeder
//   Self-checking bench for s_stream_feeder. A chunk-level model (expected
//   chunk index, tag arithmetic, word memory contents) is checked against the
//   DUT every cycle; directed scenarios pin the model with literal values and
//   a randomized phase exercises request gaps, lengths and aborts.
module tb_s_stream_feeder;

  localparam int PE_LOG = 6;
  localparam int ADDR_W = 8;
  localparam int S_W    = 128;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_busy = 1'b0;
  logic              i_request_s = 1'b0;
  logic [14:0]       i_s_total = '0;
  logic              o_mem_en;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [S_W-1:0]    i_mem_rdata = '0;
  logic [S_W-1:0]    o_s;
  logic [PE_LOG:0]   o_s_valid;

  always #5 clk = ~clk;

  s_stream_feeder #(
    .PE_LOG(PE_LOG),
    .ADDR_W(ADDR_W),
    .S_W   (S_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_busy     (i_busy),
    .i_request_s(i_request_s),
    .i_s_total  (i_s_total),
    .o_mem_en   (o_mem_en),
    .o_mem_addr (o_mem_addr),
    .i_mem_rdata(i_mem_rdata),
    .o_s        (o_s),
    .o_s_valid  (o_s_valid)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Word memory: data only valid for the cycle after a strobe, junk otherwise.
  logic [S_W-1:0] mem [256];
  always @(posedge clk) begin
    if (o_mem_en) i_mem_rdata <= mem[o_mem_addr];
    else          i_mem_rdata <= {$urandom(), $urandom(), $urandom(), $urandom()};
  end

  function automatic int sat(input int t);
    return (t > 16384) ? 16384 : t;
  endfunction

  function automatic int n_chunks(input int t);
    return (t + 63) / 64;
  endfunction

  function automatic int tag_of(input int t, input int idx);
    int n;
    n = n_chunks(t);
    return (idx < n - 1) ? 127 : t - 64 * (n - 1);
  endfunction

  // Inputs as the DUT sees them at each rising edge.
  bit rst_s = 1'b1, busy_s = 1'b0, req_s = 1'b0;
  int tot_s = 0;
  always @(posedge clk) begin
    rst_s  = rst;
    busy_s = i_busy;
    req_s  = i_request_s;
    tot_s  = int'(i_s_total);
  end

  // Chunk-level model and observation log.
  int tot_lat = 0;
  int idx = 0;
  int last_pulse = -100;
  int cyc = 0;
  int q_tag[$];
  int q_cyc[$];
  int q_addr[$];

  always @(negedge clk) begin
    cyc++;
    if (o_s_valid == 0) check("s_zero_without_valid", o_s, '0);
    if (rst_s || !busy_s) begin
      check("idle_mem_en", o_mem_en, 0);
      check("idle_mem_addr", o_mem_addr, 0);
      check("idle_valid", o_s_valid, 0);
      tot_lat    = sat(tot_s);
      idx        = 0;
      last_pulse = -100;
    end else if (tot_lat == 0) begin
      check("zero_total_mem_en", o_mem_en, 0);
      check("zero_total_valid", o_s_valid, 0);
    end else begin
      if (o_mem_en) begin
        q_addr.push_back(int'(o_mem_addr));
        check("mem_addr", o_mem_addr, idx);
      end
      if (o_s_valid != 0) begin
        q_tag.push_back(int'(o_s_valid));
        q_cyc.push_back(cyc);
        check("request_before_chunk", req_s, 1);
        check("chunk_spacing_ge3", (cyc - last_pulse) >= 3, 1);
        check("chunk_tag", o_s_valid, tag_of(tot_lat, idx));
        check("chunk_data", o_s, mem[idx]);
        last_pulse = cyc;
        idx        = (idx + 1) % n_chunks(tot_lat);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    q_tag.delete();
    q_cyc.delete();
    q_addr.delete();
  endtask

  initial begin
    int c0;
    int n127;
    int rand_pulses;
    bit found;

    for (int i = 0; i < 256; i++) mem[i] = {$urandom(), $urandom(), $urandom(), $urandom()};

    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Three chunks with wrap, request held: tags 127,127,22,127 every 3 cycles.
    i_s_total = 15'd150;
    tick();
    clear_log();
    c0 = cyc;
    i_busy = 1'b1;
    i_request_s = 1'b1;
    repeat (14) tick();
    check("t150_count", q_tag.size() >= 4, 1);
    if (q_tag.size() >= 4 && q_addr.size() >= 4) begin
      check("t150_tag0", q_tag[0], 127);
      check("t150_tag1", q_tag[1], 127);
      check("t150_tag2", q_tag[2], 22);
      check("t150_tag3", q_tag[3], 127);
      check("t150_first_latency", q_cyc[0] - c0, 4);
      check("t150_gap1", q_cyc[1] - q_cyc[0], 3);
      check("t150_gap2", q_cyc[2] - q_cyc[1], 3);
      check("t150_gap3", q_cyc[3] - q_cyc[2], 3);
      check("t150_addr0", q_addr[0], 0);
      check("t150_addr1", q_addr[1], 1);
      check("t150_addr2", q_addr[2], 2);
      check("t150_addr3", q_addr[3], 0);
    end
    i_busy = 1'b0;
    i_request_s = 1'b0;
    repeat (2) tick();

    // Exactly one word: tag 64 every time, always from address 0.
    i_s_total = 15'd64;
    tick();
    clear_log();
    i_busy = 1'b1;
    i_request_s = 1'b1;
    repeat (20) tick();
    check("t64_count", q_tag.size() >= 5, 1);
    foreach (q_tag[i]) check("t64_tag", q_tag[i], 64);
    foreach (q_addr[i]) check("t64_addr", q_addr[i], 0);
    i_busy = 1'b0;
    i_request_s = 1'b0;
    repeat (2) tick();

    // Zero length: nothing ever leaves the block.
    i_s_total = 15'd0;
    tick();
    clear_log();
    i_busy = 1'b1;
    i_request_s = 1'b1;
    repeat (50) tick();
    check("t0_no_chunks", q_tag.size(), 0);
    check("t0_no_reads", q_addr.size(), 0);
    i_busy = 1'b0;
    i_request_s = 1'b0;
    repeat (2) tick();

    // Saturation: 20000 characters behave as 256 full words.
    i_s_total = 15'd20000;
    tick();
    clear_log();
    i_busy = 1'b1;
    i_request_s = 1'b1;
    for (int i = 0; i < 1000 && q_tag.size() < 257; i++) tick();
    check("tsat_count", q_tag.size() >= 257, 1);
    if (q_tag.size() >= 257 && q_addr.size() >= 257) begin
      n127 = 0;
      for (int i = 0; i < 255; i++) if (q_tag[i] == 127) n127++;
      check("tsat_full_chunks", n127, 255);
      check("tsat_tag255", q_tag[255], 64);
      check("tsat_tag256", q_tag[256], 127);
      check("tsat_addr254", q_addr[254], 254);
      check("tsat_addr255", q_addr[255], 255);
      check("tsat_addr256", q_addr[256], 0);
    end
    i_busy = 1'b0;
    i_request_s = 1'b0;
    repeat (2) tick();

    // Abort: busy drops in the cycle after the read of address 1.
    i_s_total = 15'd150;
    tick();
    i_busy = 1'b1;
    i_request_s = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (o_mem_en && o_mem_addr == 8'd1) found = 1'b1;
    end
    check("abort_saw_addr1", found, 1);
    @(posedge clk);
    #1;
    i_busy = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("abort_valid", o_s_valid, 0);
    check("abort_s", o_s, '0);
    check("abort_mem_en", o_mem_en, 0);
    tick();
    clear_log();
    i_busy = 1'b1;
    repeat (14) tick();
    check("abort_rerun_count", q_tag.size() >= 3, 1);
    if (q_tag.size() >= 3 && q_addr.size() >= 1) begin
      check("abort_rerun_addr0", q_addr[0], 0);
      check("abort_rerun_tag0", q_tag[0], 127);
      check("abort_rerun_tag1", q_tag[1], 127);
      check("abort_rerun_tag2", q_tag[2], 22);
    end
    i_busy = 1'b0;
    i_request_s = 1'b0;
    repeat (2) tick();

    // Reset for one cycle during SEND.
    i_busy = 1'b1;
    i_request_s = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (o_s_valid != 0) found = 1'b1;
    end
    check("reset_saw_send", found, 1);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    i_request_s = 1'b0;
    @(negedge clk);
    check("reset_valid", o_s_valid, 0);
    check("reset_s", o_s, '0);
    check("reset_mem_en", o_mem_en, 0);
    check("reset_mem_addr", o_mem_addr, 0);
    clear_log();
    repeat (10) tick();
    check("reset_no_chunk_without_request", q_tag.size(), 0);
    i_request_s = 1'b1;
    repeat (6) tick();
    check("reset_chunk_after_request", q_tag.size() >= 1, 1);
    if (q_tag.size() >= 1 && q_addr.size() >= 1) begin
      check("reset_first_addr", q_addr[0], 0);
      check("reset_first_tag", q_tag[0], 127);
    end
    i_busy = 1'b0;
    i_request_s = 1'b0;
    repeat (2) tick();

    // Randomized lengths, request patterns and aborts.
    rand_pulses = 0;
    for (int seg = 0; seg < 30; seg++) begin
      case ($urandom_range(0, 5))
        0:       i_s_total = 15'($urandom_range(1, 400));
        1:       i_s_total = 15'd64;
        2:       i_s_total = 15'd65;
        3:       i_s_total = 15'd128;
        4:       i_s_total = 15'($urandom_range(16300, 20000));
        default: i_s_total = 15'($urandom_range(1, 64));
      endcase
      i_busy = 1'b0;
      repeat ($urandom_range(1, 3)) tick();
      clear_log();
      i_busy = 1'b1;
      repeat ($urandom_range(20, 200)) begin
        i_request_s = ($urandom_range(0, 9) < 7);
        if ($urandom_range(0, 49) == 0) begin
          i_busy = 1'b0;
          tick();
          i_busy = 1'b1;
        end
        tick();
      end
      rand_pulses += q_tag.size();
    end
    check("random_progress", rand_pulses > 0, 1);
    i_busy = 1'b0;
    i_request_s = 1'b0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
